epc_unit: RTL and testbench

//  - CP0 Exception Program Counter (EPC) register for the MIPS-style CPU.
//  - Hardware path: captures the restart PC when an exception is taken, with branch-delay correction.
//  - Software path: read by MFC0 and written by MTC0.
//  - Also read by hardware on ERET, which sources the return address.
//  - Sits inside the CP0 register block, beside the Status and Cause units.

---
 rtl/epc_unit_pkg.sv | 33 +++
 rtl/epc_unit.sv | 51 +++++
 tb/tb_epc_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/epc_unit_pkg.sv
// Shared CP0 definitions for the EPC register: enable levels, widths, reset value
// and the next-value source selection.
`ifndef EPC_UNIT_PKG_DEFINES
`define EPC_UNIT_PKG_DEFINES
`define ENABLE  1'b1
`define DISABLE 1'b0
`endif

package epc_unit_pkg;

  localparam int unsigned CP0_W       = 32;
  localparam int unsigned EPC_PC_STEP = 4;
  localparam logic [CP0_W-1:0] EPC_RST_VAL = CP0_W'(0);

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_SW   = 2'd1,
    SEL_HW   = 2'd2
  } epc_sel_e;

  // Exception capture outranks MTC0; a colliding software write is dropped.
  function automatic epc_sel_e epc_next_sel(input logic we_h, input logic we_s);
    epc_sel_e sel;
    sel = SEL_HOLD;
    if (we_h == `ENABLE) begin
      sel = SEL_HW;
    end else if (we_s == `ENABLE) begin
      sel = SEL_SW;
    end
    return sel;
  endfunction

endpackage

// File: rtl/epc_unit.sv
// CP0 Exception Program Counter: exception capture with delay-slot correction,
// MTC0 write, and zero-latency gated read for MFC0 / ERET.
module epc_unit
  import epc_unit_pkg::*;
#(
  parameter int unsigned       DATA_W  = CP0_W,
  parameter int unsigned       PC_STEP = EPC_PC_STEP,
  parameter logic [DATA_W-1:0] RST_VAL = DATA_W'(EPC_RST_VAL)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r_p,
  input  logic              r_h,
  input  logic              we_s,
  input  logic              we_h,
  input  logic              bd_p,
  input  logic [DATA_W-1:0] pc_p,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data
);

  logic [DATA_W-1:0] epc_q;
  logic [DATA_W-1:0] epc_d;
  logic [DATA_W-1:0] hw_val;
  epc_sel_e          sel;

  // Delay-slot faults restart at the branch; subtraction wraps modulo 2^DATA_W.
  assign hw_val = (bd_p == `ENABLE) ? (pc_p - DATA_W'(PC_STEP)) : pc_p;
  assign sel    = epc_next_sel(we_h, we_s);

  always_comb begin
    epc_d = epc_q;
    unique case (sel)
      SEL_HW:   epc_d = hw_val;
      SEL_SW:   epc_d = write_data;
      default:  epc_d = epc_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc_q <= RST_VAL;
    end else begin
      epc_q <= epc_d;
    end
  end

  // No write bypass: readers always see the pre-edge register value.
  assign read_data = ((r_p == `ENABLE) || (r_h == `ENABLE)) ? epc_q : DATA_W'(0);

endmodule

// File: tb/tb_epc_unit.sv
// Self-checking bench for epc_unit: table-driven vectors through a scoreboard
// queue, plus hand sequences for reset and long hold.
module tb_epc_unit;

  logic        clk;
  logic        rst;
  logic        r_p;
  logic        r_h;
  logic        we_s;
  logic        we_h;
  logic        bd_p;
  logic [31:0] pc_p;
  logic [31:0] write_data;
  logic [31:0] read_data;

  int unsigned n_checks;
  int unsigned n_pass;

  logic [31:0] sb_q[$];

  typedef struct {
    logic        rp;
    logic        rh;
    logic        ws;
    logic        wh;
    logic        bd;
    logic [31:0] pc;
    logic [31:0] wd;
    logic [31:0] exp_pre;
    logic [31:0] exp_post;
    string       name;
  } vec_t;

  vec_t vecs[11];

  epc_unit dut (
    .clk        (clk),
    .rst        (rst),
    .r_p        (r_p),
    .r_h        (r_h),
    .we_s       (we_s),
    .we_h       (we_h),
    .bd_p       (bd_p),
    .pc_p       (pc_p),
    .write_data (write_data),
    .read_data  (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] exp);
    n_checks++;
    if (read_data === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: read_data=0x%08h required 0x%08h", name, read_data, exp);
    end
  endtask

  task automatic check_sb(input string name);
    logic [31:0] exp;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty, read_data=0x%08h required an expected entry", name, read_data);
    end else begin
      exp = sb_q.pop_front();
      check(name, exp);
    end
  endtask

  task automatic drive(input logic rp, input logic rh, input logic ws, input logic wh,
                       input logic bd, input logic [31:0] pc, input logic [31:0] wd);
    r_p        = rp;
    r_h        = rh;
    we_s       = ws;
    we_h       = wh;
    bd_p       = bd;
    pc_p       = pc;
    write_data = wd;
  endtask

  function automatic vec_t mk(input logic rp, input logic rh, input logic ws, input logic wh,
                              input logic bd, input logic [31:0] pc, input logic [31:0] wd,
                              input logic [31:0] e_pre, input logic [31:0] e_post,
                              input string name);
    vec_t v;
    v.rp = rp; v.rh = rh; v.ws = ws; v.wh = wh; v.bd = bd;
    v.pc = pc; v.wd = wd; v.exp_pre = e_pre; v.exp_post = e_post; v.name = name;
    return v;
  endfunction

  initial begin
    n_checks = 0;
    n_pass   = 0;

    //            rp   rh   ws   wh   bd   pc            wd            pre           post
    vecs[0]  = mk(1'b0,1'b1,1'b0,1'b1,1'b0,32'h0000_0004,32'h0,        32'h0000_0000,32'h0000_0004,"hw_nobd");
    vecs[1]  = mk(1'b0,1'b1,1'b0,1'b1,1'b1,32'h0000_0004,32'h0,        32'h0000_0004,32'h0000_0000,"hw_bd");
    vecs[2]  = mk(1'b0,1'b1,1'b0,1'b1,1'b1,32'h0000_0000,32'h0,        32'h0000_0000,32'hFFFF_FFFC,"hw_bd_wrap");
    vecs[3]  = mk(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0000_000F,32'hFFFF_FFFC,32'h0000_000F,"sw_write");
    vecs[4]  = mk(1'b1,1'b1,1'b1,1'b1,1'b0,32'h0000_0100,32'hDEAD_BEEF,32'h0000_000F,32'h0000_0100,"hw_beats_sw");
    vecs[5]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h0000_0000,32'h0000_0000,"no_read_gate");
    vecs[6]  = mk(1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,        32'h1234_5677,32'h0000_0100,32'h1234_5677,"sw_unaligned");
    vecs[7]  = mk(1'b0,1'b1,1'b0,1'b1,1'b1,32'h0000_1003,32'hFFFF_FFFF,32'h1234_5677,32'h0000_0FFF,"hw_bd_unaligned");
    vecs[8]  = mk(1'b1,1'b0,1'b0,1'b0,1'b1,32'h5555_5555,32'h0,        32'h0000_0FFF,32'h0000_0FFF,"hold_bd_ignored");
    vecs[9]  = mk(1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,        32'hA5A5_A5A5,32'h0000_0000,32'h0000_0000,"sw_write_unread");
    vecs[10] = mk(1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'hA5A5_A5A5,32'hA5A5_A5A5,"read_after_unread_write");

    // Power-on reset with control inputs left undefined.
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'bx, 1'bx, 1'bx, 32'hx, 32'hx);
    #1 check("reset_initial", 32'h0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0080);
    repeat (2) begin
      @(posedge clk);
      #1 check("reset_hold_writes", 32'h0);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1 check("reset_value_after_release", 32'h0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vecs[i].rp, vecs[i].rh, vecs[i].ws, vecs[i].wh, vecs[i].bd, vecs[i].pc, vecs[i].wd);
      sb_q.push_back(vecs[i].exp_pre);
      sb_q.push_back(vecs[i].exp_post);
      #1 check_sb({vecs[i].name, "_pre"});
      @(posedge clk);
      #1 check_sb({vecs[i].name, "_post"});
    end

    // Asynchronous reset mid-cycle while a read is active.
    @(posedge clk);
    #2;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0300);
    #1 check("pre_async_reset_value", 32'hA5A5_A5A5);
    rst = 1'b1;
    #1 check("async_reset_immediate", 32'h0);
    repeat (2) begin
      @(posedge clk);
      #1 check("async_reset_blocks_writes", 32'h0);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1 check("async_reset_value_held", 32'h0);

    // Write, then long idle, then read back unchanged.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0BAD_F00D);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h7777_7777, 32'h1111_1111);
    repeat (5) @(posedge clk);
    #1 check("idle_read_gated", 32'h0);
    @(negedge clk);
    r_p = 1'b1;
    #1 check("idle_hold_value", 32'h0BAD_F00D);
    @(negedge clk);
    r_p = 1'b0;
    r_h = 1'b1;
    #1 check("idle_hold_hw_read", 32'h0BAD_F00D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
